// File: rtl/pci_wom_sched.sv
// pci_wom_sched
//   Round-robin scheduler that shares one single-dword PCI master write engine
//   among NREQ status/semaphore writers. Each request pulse is latched as a
//   pending bit. One writer is granted at a time, and its address and data are
//   captured at grant. A target retry reissues the write after a backoff gap.
//   A programmable holdoff gap is enforced after every completed or failed write.
//
// Ports
//   hb_clk       in   host bus clock
//   reset_n      in   asynchronous active-low reset
//   pci_mstr_en  in   bus-master enable; low blocks new grants only
//   holdoff      in   idle cycles enforced after a write finishes
//   req          in   per-requester 1-cycle request pulses
//   req_addr     in   per-requester dword address, [30*i +: 30]
//   req_data     in   per-requester write data,   [32*i +: 32]
//   eng_go       out  1-cycle start pulse to the write engine
//   eng_addr     out  latched address of the granted requester
//   eng_data     out  latched data of the granted requester
//   eng_done     in   write completed
//   eng_retry    in   target retry, no data moved
//   eng_abort    in   master/target abort
//   gnt_id       out  index of the current/last granted requester
//   ack          out  per-requester 1-cycle completion pulse
//   err          out  per-requester 1-cycle failure pulse (abort / retries exhausted)
//   busy         out  scheduler not idle
module pci_wom_sched #(
  parameter int NREQ      = 4,
  parameter int HOLDOFF_W = 8,
  parameter int MAX_RETRY = 15,
  parameter int BACKOFF   = 4
) (
  input  logic                    hb_clk,
  input  logic                    reset_n,
  input  logic                    pci_mstr_en,
  input  logic [HOLDOFF_W-1:0]    holdoff,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*30-1:0]      req_addr,
  input  logic [NREQ*32-1:0]      req_data,
  output logic                    eng_go,
  output logic [29:0]             eng_addr,
  output logic [31:0]             eng_data,
  input  logic                    eng_done,
  input  logic                    eng_retry,
  input  logic                    eng_abort,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int RW  = 8;                                    // MAX_RETRY <= 255
  localparam int BW  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;  // holds BACKOFF-1

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NREQ-1:0]       pending_q, pending_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [IDW-1:0]        gnt_id_q, gnt_id_d;
  logic [29:0]           eng_addr_q, eng_addr_d;
  logic [31:0]           eng_data_q, eng_data_d;
  logic                  eng_go_q, eng_go_d;
  logic [NREQ-1:0]       ack_q, ack_d;
  logic [NREQ-1:0]       err_q, err_d;
  logic [RW-1:0]         retry_cnt_q, retry_cnt_d;
  logic [BW-1:0]         back_cnt_q, back_cnt_d;
  logic [HOLDOFF_W-1:0]  hold_cnt_q, hold_cnt_d;

  // Arbitration
  logic [NREQ-1:0] pend_rot;
  logic [IDW-1:0]  win_off;
  logic [IDW:0]    win_sum;
  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    rr_nxt;
  logic [NREQ-1:0] gnt_oh;

  // Decoded events
  logic grant;
  logic ev_abort;
  logic ev_done;
  logic ev_retry;
  logic retry_last;

  // Rotate pending so the search start (rr pointer) lands at bit 0; the lowest
  // set bit of the rotated vector is the round-robin winner's offset.
  always_comb begin
    pend_rot = NREQ'({pending_q, pending_q} >> rr_q);
    win_off  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pend_rot[k]) win_off = IDW'(k);
    end
    win_sum = {1'b0, rr_q} + {1'b0, win_off};
    if (win_sum >= (IDW+1)'(NREQ)) win_sum = win_sum - (IDW+1)'(NREQ);
    win_idx = win_sum[IDW-1:0];
    rr_nxt  = {1'b0, win_idx} + (IDW+1)'(1);
    if (rr_nxt == (IDW+1)'(NREQ)) rr_nxt = '0;
  end

  assign gnt_oh = NREQ'(1) << gnt_id_q;

  assign grant      = (state_q == S_IDLE) && pci_mstr_en && (|pending_q) && (hold_cnt_q == '0);
  // Simultaneous engine pulses resolve abort > done > retry.
  assign ev_abort   = (state_q == S_WAIT) && eng_abort;
  assign ev_done    = (state_q == S_WAIT) && !eng_abort && eng_done;
  assign ev_retry   = (state_q == S_WAIT) && !eng_abort && !eng_done && eng_retry;
  assign retry_last = (retry_cnt_q == RW'(MAX_RETRY - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ev_abort || ev_done) state_d = S_HOLD;
        else if (ev_retry)       state_d = retry_last ? S_HOLD : S_BACKOFF;
      end
      S_BACKOFF: begin
        if (back_cnt_q == '0) state_d = S_ISSUE;
      end
      S_HOLD: begin
        // hold_cnt was loaded with holdoff on entry; leaving at 1 (or at 0 when
        // holdoff was 0) gives exactly holdoff idle cycles before the next grant.
        if (hold_cnt_q <= HOLDOFF_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    // A request in the same cycle as its ack/err pulse re-queues the event.
    pending_d   = (pending_q & ~(ack_q | err_q)) | req;
    rr_d        = rr_q;
    gnt_id_d    = gnt_id_q;
    eng_addr_d  = eng_addr_q;
    eng_data_d  = eng_data_q;
    eng_go_d    = (state_d == S_ISSUE);
    ack_d       = '0;
    err_d       = '0;
    retry_cnt_d = retry_cnt_q;
    back_cnt_d  = back_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    if (grant) begin
      gnt_id_d    = win_idx;
      rr_d        = rr_nxt[IDW-1:0];
      retry_cnt_d = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (win_idx == IDW'(i)) begin
          eng_addr_d = req_addr[30*i +: 30];
          eng_data_d = req_data[32*i +: 32];
        end
      end
    end

    if (ev_abort) begin
      err_d      = gnt_oh;
      hold_cnt_d = holdoff;
    end

    if (ev_done) begin
      ack_d      = gnt_oh;
      hold_cnt_d = holdoff;
    end

    if (ev_retry) begin
      if (retry_last) begin
        err_d      = gnt_oh;
        hold_cnt_d = holdoff;
      end else begin
        retry_cnt_d = retry_cnt_q + RW'(1);
        back_cnt_d  = BW'(BACKOFF - 1);
      end
    end

    if ((state_q == S_BACKOFF) && (back_cnt_q != '0)) back_cnt_d = back_cnt_q - BW'(1);

    if ((state_q == S_HOLD) && (hold_cnt_q != '0)) hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
  end

  // State register
  always_ff @(posedge hb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      rr_q        <= '0;
      gnt_id_q    <= '0;
      eng_addr_q  <= '0;
      eng_data_q  <= '0;
      eng_go_q    <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      retry_cnt_q <= '0;
      back_cnt_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      gnt_id_q    <= gnt_id_d;
      eng_addr_q  <= eng_addr_d;
      eng_data_q  <= eng_data_d;
      eng_go_q    <= eng_go_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      retry_cnt_q <= retry_cnt_d;
      back_cnt_q  <= back_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign eng_go   = eng_go_q;
  assign eng_addr = eng_addr_q;
  assign eng_data = eng_data_q;
  assign gnt_id   = gnt_id_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule
